// File: rtl/burstcount_split_gearbox.sv
// Splits one source burst (address + burstcount1 length) into a sequence of legal
// sink bursts, honouring a maximum sink length, optional page boundaries and natural alignment.
module burstcount_split_gearbox #(
    parameter int ADDR_WIDTH         = 64,
    parameter int SOURCE_BURST_WIDTH = 7,
    parameter int SINK_BURST_WIDTH   = 3,
    parameter int NATURAL_ALIGNMENT  = 0,
    parameter int PAGE_SIZE          = 0
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          m_new_req,
    input  logic [ADDR_WIDTH-1:0]         m_addr,
    input  logic [SOURCE_BURST_WIDTH-1:0] m_burstcount,
    input  logic                          s_accept_req,
    output logic                          s_req_complete,
    output logic [ADDR_WIDTH-1:0]         s_addr,
    output logic [SINK_BURST_WIDTH-1:0]   s_burstcount
);

    localparam int RW = SOURCE_BURST_WIDTH + 1;
    localparam int CW = ((RW > SINK_BURST_WIDTH) ? RW : SINK_BURST_WIDTH) + 1;
    localparam logic [CW-1:0]         MAXB      = CW'(1) << (SINK_BURST_WIDTH - 1);
    localparam logic [ADDR_WIDTH-1:0] PAGE_L    = ADDR_WIDTH'(PAGE_SIZE);
    localparam logic [ADDR_WIDTH-1:0] PAGE_MASK = PAGE_L - ADDR_WIDTH'(1);

    // Largest legal chunk starting at line a with r lines still to go.
    function automatic logic [SINK_BURST_WIDTH-1:0] chunk_size(
        input logic [ADDR_WIDTH-1:0] a,
        input logic [RW-1:0]         r
    );
        logic [CW-1:0]         c;
        logic [CW-1:0]         pow;
        logic [ADDR_WIDTH-1:0] room;
        c    = (CW'(r) > MAXB) ? MAXB : CW'(r);
        room = PAGE_L - (a & PAGE_MASK);
        if (PAGE_SIZE != 0 && room < ADDR_WIDTH'(c)) begin
            c = CW'(room);
        end
        if (NATURAL_ALIGNMENT != 0) begin
            pow = CW'(1);
            for (int i = 1; i < CW; i++) begin
                if ((CW'(1) << i) <= c &&
                    (a & ((ADDR_WIDTH'(1) << i) - ADDR_WIDTH'(1))) == '0) begin
                    pow = CW'(1) << i;
                end
            end
            c = pow;
        end
        return c[SINK_BURST_WIDTH-1:0];
    endfunction

    logic [ADDR_WIDTH-1:0]       cur_addr_q, cur_addr_d;
    logic [RW-1:0]               remaining_q, remaining_d;
    logic [ADDR_WIDTH-1:0]       s_addr_q, s_addr_d;
    logic [SINK_BURST_WIDTH-1:0] s_burstcount_q, s_burstcount_d;
    logic                        s_req_complete_q, s_req_complete_d;
    logic [SINK_BURST_WIDTH-1:0] load_k, adv_k;

    always_comb begin
        load_k = chunk_size(m_addr, RW'(m_burstcount));
        adv_k  = chunk_size(cur_addr_q, remaining_q);
        // NOTE: every next-state variable gets a hold default first, so no path leaves it unassigned (no latch).
        cur_addr_d       = cur_addr_q;
        remaining_d      = remaining_q;
        s_addr_d         = s_addr_q;
        s_burstcount_d   = s_burstcount_q;
        s_req_complete_d = s_req_complete_q;
        if (m_new_req) begin
            s_addr_d         = m_addr;
            s_burstcount_d   = load_k;
            cur_addr_d       = m_addr + ADDR_WIDTH'(load_k);
            remaining_d      = RW'(m_burstcount) - RW'(load_k);
            s_req_complete_d = (remaining_d == '0);
        end else if (s_accept_req && !s_req_complete_q) begin
            s_addr_d         = cur_addr_q;
            s_burstcount_d   = adv_k;
            cur_addr_d       = cur_addr_q + ADDR_WIDTH'(adv_k);
            remaining_d      = remaining_q - RW'(adv_k);
            s_req_complete_d = (remaining_d == '0);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cur_addr_q       <= '0;
            remaining_q      <= '0;
            s_addr_q         <= '0;
            s_burstcount_q   <= SINK_BURST_WIDTH'(1);
            s_req_complete_q <= 1'b1;
        end else begin
            cur_addr_q       <= cur_addr_d;
            remaining_q      <= remaining_d;
            s_addr_q         <= s_addr_d;
            s_burstcount_q   <= s_burstcount_d;
            s_req_complete_q <= s_req_complete_d;
        end
    end

    assign s_addr         = s_addr_q;
    assign s_burstcount   = s_burstcount_q;
    assign s_req_complete = s_req_complete_q;

    // Caller-error flags; these have no hardware effect.
    always @(posedge clk) begin
        if (reset_n && m_new_req) begin
            assert (s_req_complete_q) else $error("new burst loaded while previous burst in progress");
            assert (m_burstcount != '0) else $error("illegal zero burstcount");
        end
    end

endmodule

// File: tb/tb_burstcount_split_gearbox.sv
// Randomized and directed bench for burstcount_split_gearbox over four parameter sets,
// compared against a chunk-list reference model built by brute-force search.
module tb_burstcount_split_gearbox;

    localparam int NI = 4;
    localparam int NA_CFG [NI] = '{0, 1, 0, 1};
    localparam int PG_CFG [NI] = '{0, 0, 16, 16};
    localparam int MAXB = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        new_req [NI];
    logic [63:0] addr_in [NI];
    logic [6:0]  bc_in   [NI];
    logic        acc     [NI];
    logic        cpl     [NI];
    logic [63:0] sa      [NI];
    logic [2:0]  sbc     [NI];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: full list of chunks of the current burst, and which one is presented.
    logic [63:0] m_ca [NI][64];
    int          m_cl [NI][64];
    int          m_n  [NI];
    int          m_idx[NI];

    always #5 clk = ~clk;

    burstcount_split_gearbox u0 (
        .clk(clk), .reset_n(reset_n), .m_new_req(new_req[0]), .m_addr(addr_in[0]),
        .m_burstcount(bc_in[0]), .s_accept_req(acc[0]), .s_req_complete(cpl[0]),
        .s_addr(sa[0]), .s_burstcount(sbc[0]));
    burstcount_split_gearbox #(.NATURAL_ALIGNMENT(1)) u1 (
        .clk(clk), .reset_n(reset_n), .m_new_req(new_req[1]), .m_addr(addr_in[1]),
        .m_burstcount(bc_in[1]), .s_accept_req(acc[1]), .s_req_complete(cpl[1]),
        .s_addr(sa[1]), .s_burstcount(sbc[1]));
    burstcount_split_gearbox #(.PAGE_SIZE(16)) u2 (
        .clk(clk), .reset_n(reset_n), .m_new_req(new_req[2]), .m_addr(addr_in[2]),
        .m_burstcount(bc_in[2]), .s_accept_req(acc[2]), .s_req_complete(cpl[2]),
        .s_addr(sa[2]), .s_burstcount(sbc[2]));
    burstcount_split_gearbox #(.NATURAL_ALIGNMENT(1), .PAGE_SIZE(16)) u3 (
        .clk(clk), .reset_n(reset_n), .m_new_req(new_req[3]), .m_addr(addr_in[3]),
        .m_burstcount(bc_in[3]), .s_accept_req(acc[3]), .s_req_complete(cpl[3]),
        .s_addr(sa[3]), .s_burstcount(sbc[3]));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Largest length that respects every enabled rule, found by trying each candidate.
    function automatic int model_chunk(input int cfg, input logic [63:0] a, input int r);
        for (int c = MAXB; c >= 1; c--) begin
            if (c > r) continue;
            if (PG_CFG[cfg] != 0 && int'(a & 64'(PG_CFG[cfg] - 1)) + c > PG_CFG[cfg]) continue;
            if (NA_CFG[cfg] != 0 && ((c & (c - 1)) != 0 || (a & 64'(c - 1)) != 0)) continue;
            return c;
        end
        return 1;
    endfunction

    task automatic model_reset(input int i);
        m_n[i] = 1; m_idx[i] = 0; m_ca[i][0] = '0; m_cl[i][0] = 1;
    endtask

    task automatic model_load(input int i, input logic [63:0] a0, input int bc);
        logic [63:0] a = a0;
        int r = bc;
        m_n[i] = 0; m_idx[i] = 0;
        while (r > 0) begin
            int c = model_chunk(i, a, r);
            m_ca[i][m_n[i]] = a;
            m_cl[i][m_n[i]] = c;
            m_n[i]++;
            a += 64'(c);
            r -= c;
        end
    endtask

    function automatic bit model_idle(input int i);
        return m_idx[i] == m_n[i] - 1;
    endfunction

    task automatic compare_all();
        for (int i = 0; i < NI; i++) begin
            check($sformatf("u%0d.addr", i), sa[i], m_ca[i][m_idx[i]]);
            check($sformatf("u%0d.len", i), 64'(sbc[i]), 64'(m_cl[i][m_idx[i]]));
            check($sformatf("u%0d.cpl", i), 64'(cpl[i]), 64'(model_idle(i)));
        end
    endtask

    // Apply the inputs set by the caller for one edge, then compare at the following negedge.
    task automatic cycle();
        for (int i = 0; i < NI; i++) begin
            if (!reset_n) model_reset(i);
            else if (new_req[i]) model_load(i, addr_in[i], int'(bc_in[i]));
            else if (acc[i] && !model_idle(i)) m_idx[i]++;
        end
        @(posedge clk);
        @(negedge clk);
        compare_all();
        for (int i = 0; i < NI; i++) begin
            new_req[i] = 1'b0;
            acc[i]     = 1'b0;
        end
    endtask

    task automatic load(input int i, input logic [63:0] a, input int bc);
        new_req[i] = 1'b1;
        addr_in[i] = a;
        bc_in[i]   = 7'(bc);
    endtask

    task automatic exp_chunk(input string tag, input int i, input logic [63:0] a,
                             input int len, input bit c);
        check({tag, ".addr"}, sa[i], a);
        check({tag, ".len"}, 64'(sbc[i]), 64'(len));
        check({tag, ".cpl"}, 64'(cpl[i]), 64'(c));
    endtask

    initial begin
        reset_n = 1'b0;
        for (int i = 0; i < NI; i++) begin
            new_req[i] = 1'b0; acc[i] = 1'b0; addr_in[i] = '0; bc_in[i] = 7'd1;
            model_reset(i);
        end
        @(negedge clk);
        cycle();
        reset_n = 1'b1;
        exp_chunk("reset", 0, 64'h0, 1, 1'b1);

        load(0, 64'h100, 10);               cycle(); exp_chunk("split0", 0, 64'h100, 4, 1'b0);
        acc[0] = 1'b1;                      cycle(); exp_chunk("split1", 0, 64'h104, 4, 1'b0);
        acc[0] = 1'b1;                      cycle(); exp_chunk("split2", 0, 64'h108, 2, 1'b1);

        load(1, 64'h103, 8);                cycle(); exp_chunk("align0", 1, 64'h103, 1, 1'b0);
        acc[1] = 1'b1;                      cycle(); exp_chunk("align1", 1, 64'h104, 4, 1'b0);
        acc[1] = 1'b1;                      cycle(); exp_chunk("align2", 1, 64'h108, 2, 1'b0);
        acc[1] = 1'b1;                      cycle(); exp_chunk("align3", 1, 64'h10A, 1, 1'b1);

        load(2, 64'h0E, 4);                 cycle(); exp_chunk("page0", 2, 64'h0E, 2, 1'b0);
        acc[2] = 1'b1;                      cycle(); exp_chunk("page1", 2, 64'h10, 2, 1'b1);
        load(2, 64'h1C, 3);                 cycle(); exp_chunk("page2", 2, 64'h1C, 3, 1'b1);

        load(0, 64'h200, 6);                cycle(); exp_chunk("bp0", 0, 64'h200, 4, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cycle(); exp_chunk("bp_hold", 0, 64'h200, 4, 1'b0);
        end
        acc[0] = 1'b1;                      cycle(); exp_chunk("bp1", 0, 64'h204, 2, 1'b1);

        acc[0] = 1'b1; load(0, 64'h300, 1); cycle(); exp_chunk("b2b", 0, 64'h300, 1, 1'b1);
        acc[0] = 1'b1;                      cycle(); exp_chunk("idle_acc", 0, 64'h300, 1, 1'b1);

        load(0, 64'h100, 10);               cycle(); exp_chunk("mid0", 0, 64'h100, 4, 1'b0);
        reset_n = 1'b0; acc[0] = 1'b1;      cycle(); exp_chunk("mid_rst", 0, 64'h0, 1, 1'b1);
        reset_n = 1'b1;
        load(0, 64'h40, 2);                 cycle(); exp_chunk("post_rst", 0, 64'h40, 2, 1'b1);

        for (int n = 0; n < 4000; n++) begin
            reset_n = ($urandom_range(0, 499) != 0);
            for (int i = 0; i < NI; i++) begin
                acc[i] = ($urandom_range(0, 9) < 6);
                if (model_idle(i) && $urandom_range(0, 9) < 3) begin
                    case ($urandom_range(0, 2))
                        0:       load(i, {$urandom, $urandom}, $urandom_range(1, 64));
                        1:       load(i, 64'hFFFF_FFFF_FFFF_FFE0 + 64'($urandom_range(0, 31)),
                                      $urandom_range(1, 64));
                        default: load(i, 64'($urandom_range(0, 255)), $urandom_range(1, 64));
                    endcase
                end
            end
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
